// File: rtl/i2s_pkg.sv
// Shared types and the byte-select helper for the PCM capture path.
// Words up to MAX_SAMPLE_WIDTH bits are supported by the helper.
package i2s_pkg;

    localparam int MAX_SAMPLE_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAG  = 2'd1,
        BYTE = 2'd2
    } arb_state_t;

    typedef enum logic {
        CH_L = 1'b0,
        CH_R = 1'b1
    } ch_t;

    // LSB-first over the kept bytes; two-byte mode keeps only the top 16 bits.
    function automatic logic [7:0] byte_sel(
        input logic [MAX_SAMPLE_WIDTH-1:0] word,
        input int                          idx,
        input int                          bps,
        input int                          sw
    );
        logic [MAX_SAMPLE_WIDTH-1:0] shifted;
        if (bps == 2) begin
            shifted = word >> (sw - 16 + 8 * idx);
        end else begin
            shifted = word >> (8 * idx);
        end
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/pcm_fifo_arbiter_if.sv
// PCM source strobes and capture-FIFO write port bundled for the arbiter.
// master = arbiter side, slave = the receivers/FIFO environment.
interface pcm_fifo_arbiter_if #(
    parameter int SAMPLE_WIDTH = 24
);
    logic [SAMPLE_WIDTH-1:0] pcm_l;
    logic [SAMPLE_WIDTH-1:0] pcm_r;
    logic                    pcm_l_valid;
    logic                    pcm_r_valid;
    logic                    fifo_full;
    logic                    fifo_wr_en;
    logic [7:0]              fifo_wr_data;

    modport master (
        input  pcm_l, pcm_r, pcm_l_valid, pcm_r_valid, fifo_full,
        output fifo_wr_en, fifo_wr_data
    );

    modport slave (
        output pcm_l, pcm_r, pcm_l_valid, pcm_r_valid, fifo_full,
        input  fifo_wr_en, fifo_wr_data
    );
endinterface

// File: rtl/pcm_hold_slot.sv
// One-deep sample hold with pending flag and saturating drop counter.
// A clear coinciding with a new strobe keeps the slot pending with the new word.
module pcm_hold_slot #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int OVR_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    valid,
    input  logic [SAMPLE_WIDTH-1:0] pcm,
    input  logic                    clear,
    output logic                    pending,
    output logic [SAMPLE_WIDTH-1:0] word,
    output logic [OVR_WIDTH-1:0]    overrun
);
    logic                    pending_reg, pending_next;
    logic [SAMPLE_WIDTH-1:0] word_reg, word_next;
    logic [OVR_WIDTH-1:0]    ovr_reg, ovr_next;
    logic                    capture;
    logic                    drop;

    always_comb begin
        capture      = valid && enable && (!pending_reg || clear);
        drop         = valid && enable && pending_reg && !clear;
        pending_next = pending_reg;
        word_next    = word_reg;
        ovr_next     = ovr_reg;
        if (clear) begin
            pending_next = 1'b0;
        end
        if (capture) begin
            pending_next = 1'b1;
            word_next    = pcm;
        end
        if (drop && (ovr_reg != {OVR_WIDTH{1'b1}})) begin
            ovr_next = ovr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_reg <= 1'b0;
            word_reg    <= '0;
            ovr_reg     <= '0;
        end else begin
            pending_reg <= pending_next;
            word_reg    <= word_next;
            ovr_reg     <= ovr_next;
        end
    end

    assign pending = pending_reg;
    assign word    = word_reg;
    assign overrun = ovr_reg;

endmodule

// File: rtl/pcm_fifo_arbiter.sv
// Round-robin arbiter writing L/R PCM samples as atomic byte bursts into the
// capture FIFO. Define PCM_ARB_TAG_EN to prefix each sample with a header byte.
module pcm_fifo_arbiter
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH     = 24,
    parameter int BYTES_PER_SAMPLE = 3,
    parameter int OVR_WIDTH        = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    pcm_fifo_arbiter_if.master    bus,
    output logic                  busy,
    output logic                  grant_ch,
    output logic [OVR_WIDTH-1:0]  overrun_l,
    output logic [OVR_WIDTH-1:0]  overrun_r
);
    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_SAMPLE - 1);
    localparam logic [1:0] DONE_IDX = 2'(BYTES_PER_SAMPLE);
`ifdef PCM_ARB_TAG_EN
    localparam arb_state_t FIRST_STATE = TAG;
`else
    localparam arb_state_t FIRST_STATE = BYTE;
`endif

    logic [1:0]              slot_valid;
    logic [1:0]              slot_pending;
    logic [1:0]              slot_clear;
    logic [SAMPLE_WIDTH-1:0] slot_pcm  [2];
    logic [SAMPLE_WIDTH-1:0] slot_word [2];
    logic [OVR_WIDTH-1:0]    slot_ovr  [2];

    assign slot_valid  = {bus.pcm_r_valid, bus.pcm_l_valid};
    assign slot_pcm[0] = bus.pcm_l;
    assign slot_pcm[1] = bus.pcm_r;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            pcm_hold_slot #(
                .SAMPLE_WIDTH (SAMPLE_WIDTH),
                .OVR_WIDTH    (OVR_WIDTH)
            ) u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .enable  (enable),
                .valid   (slot_valid[gi]),
                .pcm     (slot_pcm[gi]),
                .clear   (slot_clear[gi]),
                .pending (slot_pending[gi]),
                .word    (slot_word[gi]),
                .overrun (slot_ovr[gi])
            );
        end
    endgenerate

    arb_state_t state_reg, state_next;
    logic [1:0] idx_reg, idx_next;
    ch_t        grant_reg, grant_next;
    ch_t        prio_reg, prio_next;
    logic       wr_en_reg, wr_en_next;
    logic [7:0] wr_data_reg, wr_data_next;
`ifdef PCM_ARB_TAG_EN
    logic [1:0][3:0] seq_reg, seq_next;
`endif

    ch_t        grant_sel;
    logic       grant_req;
    logic       issue;
    logic       last_issue;
    logic [7:0] data_byte;
    logic [7:0] tag_byte;

    // The last-served channel loses ties; a lone pending slot always wins.
    always_comb begin
        grant_req = enable && (|slot_pending);
        grant_sel = prio_reg;
        if (slot_pending == 2'b01) begin
            grant_sel = CH_L;
        end else if (slot_pending == 2'b10) begin
            grant_sel = CH_R;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_req) state_next = FIRST_STATE;
            TAG:     if (issue) state_next = BYTE;
            BYTE:    if (idx_reg == DONE_IDX) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A write never follows a write, so fifo_full always reflects every prior byte.
    always_comb begin
        issue      = !wr_en_reg && !bus.fifo_full &&
                     ((state_reg == TAG) || ((state_reg == BYTE) && (idx_reg != DONE_IDX)));
        last_issue = issue && (state_reg == BYTE) && (idx_reg == LAST_IDX);
        data_byte  = byte_sel(MAX_SAMPLE_WIDTH'(slot_word[grant_reg]), int'(idx_reg),
                              BYTES_PER_SAMPLE, SAMPLE_WIDTH);
`ifdef PCM_ARB_TAG_EN
        tag_byte   = {grant_reg, 3'b000, seq_reg[grant_reg]};
        seq_next   = seq_reg;
        if (last_issue) begin
            seq_next[grant_reg] = seq_reg[grant_reg] + 4'd1;
        end
`else
        tag_byte   = 8'h00;
`endif
        wr_en_next   = issue;
        wr_data_next = wr_data_reg;
        if (issue) begin
            wr_data_next = (state_reg == TAG) ? tag_byte : data_byte;
        end
        idx_next   = idx_reg;
        grant_next = grant_reg;
        prio_next  = prio_reg;
        if ((state_reg == IDLE) && grant_req) begin
            grant_next = grant_sel;
            prio_next  = (grant_sel == CH_L) ? CH_R : CH_L;
            idx_next   = 2'd0;
        end
        if (issue && (state_reg == BYTE)) begin
            idx_next = idx_reg + 2'd1;
        end
        slot_clear = 2'b00;
        if (last_issue) begin
            slot_clear[grant_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_reg     <= 2'd0;
            grant_reg   <= CH_L;
            prio_reg    <= CH_L;
            wr_en_reg   <= 1'b0;
            wr_data_reg <= 8'h00;
`ifdef PCM_ARB_TAG_EN
            seq_reg     <= '0;
`endif
        end else begin
            idx_reg     <= idx_next;
            grant_reg   <= grant_next;
            prio_reg    <= prio_next;
            wr_en_reg   <= wr_en_next;
            wr_data_reg <= wr_data_next;
`ifdef PCM_ARB_TAG_EN
            seq_reg     <= seq_next;
`endif
        end
    end

    assign bus.fifo_wr_en   = wr_en_reg;
    assign bus.fifo_wr_data = wr_data_reg;
    assign busy             = (state_reg != IDLE);
    assign grant_ch         = grant_reg;
    assign overrun_l        = slot_ovr[0];
    assign overrun_r        = slot_ovr[1];

endmodule

// File: tb/tb_pcm_fifo_arbiter.sv
// Scoreboard bench for pcm_fifo_arbiter: expected bytes are queued at stimulus
// time and popped by a write monitor; per-scenario tasks check timing and counters.
`timescale 1ns/1ps
module tb_pcm_fifo_arbiter;

    localparam int SW = 24;
`ifdef PCM_ARB_TAG_EN
    localparam int NW = 4;
`else
    localparam int NW = 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       busy;
    logic       grant_ch;
    logic [7:0] overrun_l;
    logic [7:0] overrun_r;

    pcm_fifo_arbiter_if #(.SAMPLE_WIDTH(SW)) bus_if ();

    pcm_fifo_arbiter #(
        .SAMPLE_WIDTH     (SW),
        .BYTES_PER_SAMPLE (3),
        .OVR_WIDTH        (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .bus       (bus_if),
        .busy      (busy),
        .grant_ch  (grant_ch),
        .overrun_l (overrun_l),
        .overrun_r (overrun_r)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         writes_seen = 0;
    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;
    logic [3:0] seq_model [2];
    logic       full_at_dec = 1'b0;
    logic       prev_wr = 1'b0;

    // fifo_full as the DUT saw it when deciding the strobe that follows this edge
    always @(posedge clk) full_at_dec <= bus_if.fifo_full;

    always @(negedge clk) begin
        if (rst_n && bus_if.fifo_wr_en) begin
            writes_seen++;
            $display("WR t=%0t data=%02h grant=%0d", $time, bus_if.fifo_wr_data, grant_ch);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra got %02h expected no write", bus_if.fifo_wr_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus_if.fifo_wr_data !== mon_exp) begin
                    errors++;
                    $display("FAIL scoreboard_data got %02h expected %02h", bus_if.fifo_wr_data, mon_exp);
                end
            end
            checks++;
            if (full_at_dec !== 1'b0) begin
                errors++;
                $display("FAIL write_while_full got full=%0b expected 0", full_at_dec);
            end
            checks++;
            if (prev_wr !== 1'b0) begin
                errors++;
                $display("FAIL write_gap got back-to-back=%0b expected 0", prev_wr);
            end
        end
        prev_wr = rst_n ? bus_if.fifo_wr_en : 1'b0;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic vl, input logic vr, input logic [SW-1:0] wl, input logic [SW-1:0] wr);
        bus_if.pcm_l       = wl;
        bus_if.pcm_r       = wr;
        bus_if.pcm_l_valid = vl;
        bus_if.pcm_r_valid = vr;
        @(negedge clk);
        bus_if.pcm_l_valid = 1'b0;
        bus_if.pcm_r_valid = 1'b0;
    endtask

    task automatic push_sample(input int ch, input logic [SW-1:0] w);
`ifdef PCM_ARB_TAG_EN
        exp_q.push_back({ch[0], 3'b000, seq_model[ch]});
        seq_model[ch] = seq_model[ch] + 4'd1;
`endif
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[23:16]);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        tick(1);
        while ((busy || exp_q.size() != 0) && n < 400) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL %s_timeout got busy=%0b queued=%0d expected idle", name, busy, exp_q.size());
        end
        tick(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        bus_if.fifo_full = 1'b0;
        tick(3);
        checks++;
        if (bus_if.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %0b expected 0", bus_if.fifo_wr_en); end
        checks++;
        if (bus_if.fifo_wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got %02h expected 00", bus_if.fifo_wr_data); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b expected 0", busy); end
        checks++;
        if (grant_ch !== 1'b0) begin errors++; $display("FAIL reset_grant got %0b expected 0", grant_ch); end
        checks++;
        if (overrun_l !== 8'd0 || overrun_r !== 8'd0) begin
            errors++; $display("FAIL reset_overrun got %0d/%0d expected 0/0", overrun_l, overrun_r);
        end
        exp_q.delete();
        seq_model[0] = 4'd0;
        seq_model[1] = 4'd0;
        rst_n = 1'b1;
        enable = 1'b1;
        tick(5);
        checks++;
        if (busy !== 1'b0 || writes_seen !== 0 && bus_if.fifo_wr_en !== 1'b0) begin
            errors++; $display("FAIL reset_no_pending got busy=%0b wr_en=%0b expected 0/0", busy, bus_if.fifo_wr_en);
        end
    endtask

    task automatic test_single();
        logic exp_busy, exp_wr;
        push_sample(0, 24'hABCDEF);
        strobe(1'b1, 1'b0, 24'hABCDEF, '0);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy k=0 got %0b expected 0", busy); end
        for (int k = 1; k <= 2 * NW + 1; k++) begin
            tick(1);
            exp_busy = (k <= 2 * NW);
            exp_wr   = (k >= 2) && (k <= 2 * NW) && (k % 2 == 0);
            checks++;
            if (busy !== exp_busy) begin errors++; $display("FAIL single_busy k=%0d got %0b expected %0b", k, busy, exp_busy); end
            checks++;
            if (bus_if.fifo_wr_en !== exp_wr) begin
                errors++; $display("FAIL single_wr_en k=%0d got %0b expected %0b", k, bus_if.fifo_wr_en, exp_wr);
            end
        end
        checks++;
        if (overrun_l !== 8'd0) begin errors++; $display("FAIL single_overrun got %0d expected 0", overrun_l); end
        wait_idle("single");
    endtask

    task automatic test_round_robin();
        push_sample(1, 24'h333333);
        strobe(1'b0, 1'b1, '0, 24'h333333);
        tick(1);
        checks++;
        if (grant_ch !== 1'b1) begin errors++; $display("FAIL rr_grant_r got %0b expected 1", grant_ch); end
        wait_idle("rr_r");
        push_sample(0, 24'h111111);
        push_sample(1, 24'h222222);
        strobe(1'b1, 1'b1, 24'h111111, 24'h222222);
        tick(1);
        checks++;
        if (grant_ch !== 1'b0) begin errors++; $display("FAIL rr_grant_l_first got %0b expected 0", grant_ch); end
        wait_idle("rr_both");
    endtask

    task automatic test_back_to_back();
        push_sample(0, 24'h5A6B7C);
        strobe(1'b1, 1'b0, 24'h5A6B7C, '0);
        tick(2 * NW - 1);
        push_sample(0, 24'h0F1E2D);
        strobe(1'b1, 1'b0, 24'h0F1E2D, '0);
        wait_idle("b2b");
        checks++;
        if (overrun_l !== 8'd0) begin errors++; $display("FAIL b2b_overrun got %0d expected 0", overrun_l); end
    endtask

    task automatic test_full_stall();
        int w0, n;
        w0 = writes_seen;
        n = 0;
        push_sample(0, 24'h445566);
        strobe(1'b1, 1'b0, 24'h445566, '0);
        while (bus_if.fifo_wr_en !== 1'b1 && n < 10) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= 10) begin errors++; $display("FAIL stall_first_byte got no write expected write"); end
        bus_if.fifo_full = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            checks++;
            if (bus_if.fifo_wr_en !== 1'b0) begin
                errors++; $display("FAIL stall_wr_en k=%0d got %0b expected 0", k, bus_if.fifo_wr_en);
            end
        end
        bus_if.fifo_full = 1'b0;
        wait_idle("stall");
        checks++;
        if (writes_seen - w0 !== NW) begin errors++; $display("FAIL stall_count got %0d expected %0d", writes_seen - w0, NW); end
    endtask

    task automatic test_enable_drop();
        int n, w0;
        logic [7:0] ol, orr;
        n = 0;
        push_sample(0, 24'h778899);
        strobe(1'b1, 1'b0, 24'h778899, '0);
        strobe(1'b0, 1'b1, '0, 24'hAA55CC);
        while (bus_if.fifo_wr_en !== 1'b1 && n < 10) begin
            tick(1);
            n++;
        end
        enable = 1'b0;
        wait_idle("endrop_l");
        ol = overrun_l;
        orr = overrun_r;
        w0 = writes_seen;
        strobe(1'b1, 1'b1, 24'h010101, 24'h020202);
        tick(10);
        checks++;
        if (writes_seen !== w0) begin errors++; $display("FAIL endrop_writes got %0d expected %0d", writes_seen, w0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL endrop_busy got %0b expected 0", busy); end
        checks++;
        if (overrun_l !== ol || overrun_r !== orr) begin
            errors++; $display("FAIL endrop_overrun got %0d/%0d expected %0d/%0d", overrun_l, overrun_r, ol, orr);
        end
        push_sample(1, 24'hAA55CC);
        enable = 1'b1;
        wait_idle("endrop_r");
        tick(10);
        checks++;
        if (writes_seen - w0 !== NW) begin errors++; $display("FAIL endrop_resume got %0d expected %0d", writes_seen - w0, NW); end
    endtask

    task automatic test_saturate();
        logic [7:0] orr;
        orr = overrun_r;
        bus_if.fifo_full = 1'b1;
        push_sample(0, 24'h0A0B0C);
        strobe(1'b1, 1'b0, 24'h0A0B0C, '0);
        for (int i = 0; i < 300; i++) begin
            bus_if.pcm_l = SW'(i);
            bus_if.pcm_l_valid = 1'b1;
            tick(1);
        end
        bus_if.pcm_l_valid = 1'b0;
        tick(2);
        checks++;
        if (overrun_l !== 8'd255) begin errors++; $display("FAIL sat_overrun_l got %0d expected 255", overrun_l); end
        checks++;
        if (overrun_r !== orr) begin errors++; $display("FAIL sat_overrun_r got %0d expected %0d", overrun_r, orr); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL sat_busy got %0b expected 1", busy); end
        bus_if.fifo_full = 1'b0;
        wait_idle("sat");
    endtask

`ifdef PCM_ARB_TAG_EN
    task automatic test_tag();
        test_reset();
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h01);
        strobe(1'b0, 1'b1, '0, 24'h010203);
        wait_idle("tag1");
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h06);
        exp_q.push_back(8'h05);
        exp_q.push_back(8'h04);
        strobe(1'b0, 1'b1, '0, 24'h040506);
        wait_idle("tag2");
    endtask
`endif

    initial begin
        bus_if.pcm_l       = '0;
        bus_if.pcm_r       = '0;
        bus_if.pcm_l_valid = 1'b0;
        bus_if.pcm_r_valid = 1'b0;
        bus_if.fifo_full   = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_full_stall();
        test_enable_drop();
        test_saturate();
`ifdef PCM_ARB_TAG_EN
        test_tag();
`endif
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d expected 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
